// File: rtl/dyna_bus_sequencer.sv
// Round-robin Dynamixel-style command sequencer: frames a request, sends it over a half-duplex link, parses the status reply.
// Grant lands one cycle after req; TX stalls byte-for-byte on tx_ready; the reply window is fixed from RX entry.
module dyna_bus_sequencer #(
    parameter int TIMEOUT_CYC = 50000,
    parameter int TURN_CYC    = 100
) (
    input  logic        CLOCK_50,
    input  logic        reset,
    input  logic [1:0]  req,
    input  logic [15:0] cmd_id,
    input  logic [15:0] cmd_instr,
    input  logic [15:0] cmd_addr,
    input  logic [31:0] cmd_data,
    output logic [1:0]  gnt,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    input  logic        tx_busy,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic        dir,
    output logic        done,
    output logic [1:0]  err_code,
    output logic [7:0]  status,
    output logic [15:0] rdata
);
    localparam int CNT_MAX = (TIMEOUT_CYC > TURN_CYC) ? TIMEOUT_CYC : TURN_CYC;
    localparam int CW      = $clog2(CNT_MAX + 1);
    localparam logic [7:0] INSTR_READ  = 8'h02;
    localparam logic [7:0] INSTR_WRITE = 8'h03;
    localparam logic [7:0] BCAST_ID    = 8'hFE;

    typedef enum logic [2:0] {IDLE, TX, DRAIN, RX, DONE} state_t;
    typedef enum logic [2:0] {RX_SYNC0, RX_SYNC1, RX_ID, RX_LEN, RX_ERR, RX_PARAM, RX_CHK} rxph_t;

    state_t         state, state_nx;
    rxph_t          rxph;
    logic           sel, last;
    logic [7:0]     id_q, instr_q, addr_q;
    logic [15:0]    data_q;
    logic [3:0]     idx, last_idx;
    logic [CW-1:0]  cnt;
    logic [7:0]     pkt_len, p0, p1, p2, chk, tx_byte;
    logic [7:0]     r_id, r_len, r_err, r_sum, r_cnt;
    logic [15:0]    r_dat;
    logic           xfer, turn_done, rx_fin, rx_tmo;

    // On a tie the requester not served last wins; a lone requester always wins.
    assign sel       = (req == 2'b11) ? ~last : req[1];
    assign xfer      = tx_valid && tx_ready;
    assign turn_done = (state == DRAIN) && !tx_busy && (cnt == CW'(TURN_CYC - 1));
    assign rx_fin    = (state == RX) && rx_valid && (rxph == RX_CHK);
    assign rx_tmo    = (state == RX) && (cnt == CW'(TIMEOUT_CYC - 1));
    assign tx_valid  = (state == TX);
    assign tx_data   = tx_valid ? tx_byte : 8'h00;
    assign done      = (state == DONE);

    always_comb begin
        pkt_len  = 8'h02;
        last_idx = 4'd5;
        p0       = 8'h00;
        p1       = 8'h00;
        p2       = 8'h00;
        if (instr_q == INSTR_WRITE) begin
            pkt_len  = 8'h05;
            last_idx = 4'd8;
            p0       = addr_q;
            p1       = data_q[7:0];
            p2       = data_q[15:8];
        end else if (instr_q == INSTR_READ) begin
            pkt_len  = 8'h04;
            last_idx = 4'd7;
            p0       = addr_q;
            p1       = 8'h02;
        end
        chk = ~(id_q + pkt_len + instr_q + p0 + p1 + p2);
        case (idx)
            4'd0, 4'd1: tx_byte = 8'hFF;
            4'd2:       tx_byte = id_q;
            4'd3:       tx_byte = pkt_len;
            4'd4:       tx_byte = instr_q;
            4'd5:       tx_byte = p0;
            4'd6:       tx_byte = p1;
            4'd7:       tx_byte = p2;
            default:    tx_byte = 8'h00;
        endcase
        if (idx == last_idx) tx_byte = chk;
    end

    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (req != 2'b00) state_nx = TX;
            TX:      if (xfer && idx == last_idx) state_nx = DRAIN;
            DRAIN:   if (turn_done) state_nx = (id_q == BCAST_ID) ? DONE : RX;
            RX:      if (rx_fin || rx_tmo) state_nx = DONE;
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            gnt      <= 2'b00;
            dir      <= 1'b0;
            last     <= 1'b1;  // requester 0 takes the first tie
            id_q     <= 8'h00;
            instr_q  <= 8'h00;
            addr_q   <= 8'h00;
            data_q   <= 16'h0000;
            idx      <= 4'd0;
            cnt      <= '0;
            rxph     <= RX_SYNC0;
            r_id     <= 8'h00;
            r_len    <= 8'h00;
            r_err    <= 8'h00;
            r_sum    <= 8'h00;
            r_cnt    <= 8'h00;
            r_dat    <= 16'h0000;
            err_code <= 2'd0;
            status   <= 8'h00;
            rdata    <= 16'h0000;
        end else begin
            case (state)
                IDLE: if (req != 2'b00) begin
                    gnt     <= sel ? 2'b10 : 2'b01;
                    dir     <= 1'b1;
                    id_q    <= sel ? cmd_id[15:8]    : cmd_id[7:0];
                    instr_q <= sel ? cmd_instr[15:8] : cmd_instr[7:0];
                    addr_q  <= sel ? cmd_addr[15:8]  : cmd_addr[7:0];
                    data_q  <= sel ? cmd_data[31:16] : cmd_data[15:0];
                    idx     <= 4'd0;
                    r_err   <= 8'h00;
                    r_dat   <= 16'h0000;
                end
                TX: if (xfer) begin
                    if (idx == last_idx) cnt <= '0;
                    else                 idx <= idx + 4'd1;
                end
                DRAIN: begin
                    if (tx_busy) begin
                        cnt <= '0;
                    end else if (turn_done) begin
                        dir  <= 1'b0;
                        cnt  <= '0;
                        rxph <= RX_SYNC0;
                        if (id_q == BCAST_ID) begin
                            err_code <= 2'd0;
                            status   <= 8'h00;
                            rdata    <= 16'h0000;
                        end
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                RX: begin
                    cnt <= cnt + CW'(1);
                    if (rx_valid) begin
                        case (rxph)
                            RX_SYNC0: if (rx_data == 8'hFF) rxph <= RX_SYNC1;
                            RX_SYNC1: rxph <= (rx_data == 8'hFF) ? RX_ID : RX_SYNC0;
                            RX_ID: begin
                                r_id  <= rx_data;
                                r_sum <= rx_data;
                                rxph  <= RX_LEN;
                            end
                            RX_LEN: begin
                                r_len <= rx_data;
                                r_sum <= r_sum + rx_data;
                                r_cnt <= 8'h00;
                                rxph  <= RX_ERR;
                            end
                            RX_ERR: begin
                                r_err <= rx_data;
                                r_sum <= r_sum + rx_data;
                                rxph  <= (r_len <= 8'h02) ? RX_CHK : RX_PARAM;
                            end
                            RX_PARAM: begin
                                r_sum <= r_sum + rx_data;
                                if (r_cnt == 8'h00) r_dat[7:0]  <= rx_data;
                                if (r_cnt == 8'h01) r_dat[15:8] <= rx_data;
                                r_cnt <= r_cnt + 8'h01;
                                if (r_cnt == r_len - 8'h03) rxph <= RX_CHK;
                            end
                            default: begin
                                // ID mismatch outranks a bad checksum
                                err_code <= (r_id != id_q)        ? 2'd3 :
                                            (rx_data != ~r_sum)   ? 2'd2 : 2'd0;
                                status   <= r_err;
                                rdata    <= r_dat;
                                rxph     <= RX_SYNC0;
                            end
                        endcase
                    end
                    if (!rx_fin && rx_tmo) begin
                        err_code <= 2'd1;
                        status   <= 8'h00;
                        rdata    <= 16'h0000;
                    end
                end
                DONE: begin
                    gnt  <= 2'b00;
                    last <= gnt[1];
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_dyna_bus_sequencer.sv
// Directed table-driven bench for dyna_bus_sequencer with short timing parameters.
module tb_dyna_bus_sequencer;
    localparam int TMO  = 40;
    localparam int TURN = 3;

    logic        clk = 1'b0;
    logic        reset;
    logic [1:0]  req;
    logic [15:0] cmd_id, cmd_instr, cmd_addr;
    logic [31:0] cmd_data;
    logic [1:0]  gnt;
    logic [7:0]  tx_data;
    logic        tx_valid, tx_ready, tx_busy;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        dir, done;
    logic [1:0]  err_code;
    logic [7:0]  status;
    logic [15:0] rdata;

    int nchk = 0;
    int nerr = 0;

    always #5 clk = ~clk;

    dyna_bus_sequencer #(.TIMEOUT_CYC(TMO), .TURN_CYC(TURN)) dut (
        .CLOCK_50(clk), .reset(reset), .req(req),
        .cmd_id(cmd_id), .cmd_instr(cmd_instr), .cmd_addr(cmd_addr), .cmd_data(cmd_data),
        .gnt(gnt), .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .tx_busy(tx_busy), .rx_data(rx_data), .rx_valid(rx_valid), .dir(dir),
        .done(done), .err_code(err_code), .status(status), .rdata(rdata)
    );

    typedef struct packed {
        logic [1:0]  rq;
        logic [1:0]  g;
        logic [7:0]  id;
        logic [7:0]  instr;
        logic [7:0]  addr;
        logic [15:0] data;
        logic [3:0]  ntx;
        logic [71:0] tx;     // byte 0 in bits [7:0]
        logic [3:0]  nrx;
        logic [79:0] rx;
        logic [1:0]  err;
        logic        chk_st;
        logic        chk_rd;
        logic [7:0]  stat;
        logic [15:0] rdat;
        logic [4:0]  stall_at;
        logic        drop;
    } vec_t;

    vec_t vecs[12];

    task automatic check(input string name, input logic ok, input logic [31:0] act, input logic [31:0] exp);
        nchk++;
        if (!ok) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic run_vec(input vec_t v);
        int n;
        int bad;
        logic [7:0] eb;
        cmd_id = 16'h3333; cmd_instr = 16'h0303; cmd_addr = 16'h4444; cmd_data = 32'h5555_5555;
        if (v.g[0]) begin
            cmd_id[7:0] = v.id; cmd_instr[7:0] = v.instr; cmd_addr[7:0] = v.addr; cmd_data[15:0] = v.data;
        end
        if (v.g[1]) begin
            cmd_id[15:8] = v.id; cmd_instr[15:8] = v.instr; cmd_addr[15:8] = v.addr; cmd_data[31:16] = v.data;
        end
        req = v.rq; tx_ready = 1'b1; tx_busy = 1'b1;
        @(negedge clk);
        check("gnt", gnt == v.g, {30'd0, gnt}, {30'd0, v.g});
        check("dir_tx", dir == 1'b1, {31'd0, dir}, 32'd1);
        if (v.drop) req = 2'b00;
        for (int i = 0; i < int'(v.ntx); i++) begin
            eb = v.tx[8*i +: 8];
            if (i == int'(v.stall_at)) begin
                tx_ready = 1'b0;
                bad = 0;
                for (int k = 0; k < 20; k++) begin
                    @(negedge clk);
                    if (!tx_valid || tx_data != eb) bad++;
                end
                check("stall_stable", bad == 0, bad, 0);
                tx_ready = 1'b1;
            end
            check($sformatf("tx_byte%0d", i), tx_valid && tx_data == eb, {23'd0, tx_valid, tx_data}, {24'd1, eb});
            @(negedge clk);
        end
        repeat (2) @(negedge clk);
        tx_busy = 1'b0;
        n = 0;
        while (dir && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("dir_release", !dir && !tx_valid, {30'd0, dir, tx_valid}, 32'd0);
        if (v.id == 8'hFE) begin
            check("bcast_done", done == 1'b1, {31'd0, done}, 32'd1);
        end else if (v.nrx == 4'd0) begin
            n = 0;
            while (!done && n < TMO + 10) begin
                @(negedge clk);
                n++;
            end
            check("timeout_cycles", n == TMO, n, TMO);
        end else begin
            for (int j = 0; j < int'(v.nrx); j++) begin
                rx_data = v.rx[8*j +: 8]; rx_valid = 1'b1;
                @(negedge clk);
                rx_valid = 1'b0;
            end
            check("reply_done", done == 1'b1, {31'd0, done}, 32'd1);
        end
        check("err_code", err_code == v.err, {30'd0, err_code}, {30'd0, v.err});
        if (v.chk_st) check("status", status == v.stat, {24'd0, status}, {24'd0, v.stat});
        if (v.chk_rd) check("rdata", rdata == v.rdat, {16'd0, rdata}, {16'd0, v.rdat});
        @(negedge clk);
        check("done_pulse", done == 1'b0 && gnt == 2'b00, {29'd0, done, gnt}, 32'd0);
    endtask

    function automatic vec_t mk(input logic [1:0] rq, input logic [1:0] g, input logic [7:0] id,
                                input logic [7:0] instr, input logic [7:0] addr, input logic [15:0] data,
                                input logic [3:0] ntx, input logic [71:0] tx, input logic [3:0] nrx,
                                input logic [79:0] rx, input logic [1:0] err, input logic chk_st,
                                input logic chk_rd, input logic [7:0] stat, input logic [15:0] rdat);
        vec_t v;
        v.rq = rq; v.g = g; v.id = id; v.instr = instr; v.addr = addr; v.data = data;
        v.ntx = ntx; v.tx = tx; v.nrx = nrx; v.rx = rx; v.err = err;
        v.chk_st = chk_st; v.chk_rd = chk_rd; v.stat = stat; v.rdat = rdat;
        v.stall_at = 5'h1F; v.drop = 1'b0;
        return v;
    endfunction

    initial begin
        int n;
        // READ from requester 1, then WRITE from requester 0 (leaves requester 0 last served)
        vecs[0] = mk(2'b10, 2'b10, 8'h01, 8'h02, 8'h24, 16'h0000, 4'd8,
                     {8'hD2, 8'h02, 8'h24, 8'h02, 8'h04, 8'h01, 8'hFF, 8'hFF}, 4'd8,
                     {8'hF8, 8'h02, 8'h00, 8'h00, 8'h04, 8'h01, 8'hFF, 8'hFF}, 2'd0, 1'b1, 1'b1, 8'h00, 16'h0200);
        vecs[1] = mk(2'b01, 2'b01, 8'h01, 8'h03, 8'h1E, 16'h0200, 4'd9,
                     {8'hD6, 8'h02, 8'h00, 8'h1E, 8'h03, 8'h05, 8'h01, 8'hFF, 8'hFF}, 4'd6,
                     {8'hFC, 8'h00, 8'h02, 8'h01, 8'hFF, 8'hFF}, 2'd0, 1'b1, 1'b0, 8'h00, 16'h0000);
        vecs[1].drop = 1'b1;
        // both requesting: strict alternation starting with requester 1
        vecs[2] = mk(2'b11, 2'b10, 8'h01, 8'h01, 8'h00, 16'h0000, 4'd6,
                     {8'hFB, 8'h01, 8'h02, 8'h01, 8'hFF, 8'hFF}, 4'd6,
                     {8'hFC, 8'h00, 8'h02, 8'h01, 8'hFF, 8'hFF}, 2'd0, 1'b1, 1'b0, 8'h00, 16'h0000);
        vecs[3] = mk(2'b11, 2'b01, 8'h01, 8'h01, 8'h00, 16'h0000, 4'd6,
                     {8'hFB, 8'h01, 8'h02, 8'h01, 8'hFF, 8'hFF}, 4'd6,
                     {8'hDC, 8'h20, 8'h02, 8'h01, 8'hFF, 8'hFF}, 2'd0, 1'b1, 1'b0, 8'h20, 16'h0000);
        vecs[4] = vecs[2];
        vecs[4].stall_at = 5'd2;
        vecs[5] = mk(2'b11, 2'b01, 8'h01, 8'h01, 8'h00, 16'h0000, 4'd6,
                     {8'hFB, 8'h01, 8'h02, 8'h01, 8'hFF, 8'hFF}, 4'd9,
                     {8'h3C, 8'h77, 8'h12, 8'h34, 8'h00, 8'h05, 8'h01, 8'hFF, 8'hFF}, 2'd0, 1'b1, 1'b1, 8'h00, 16'h1234);
        // reply errors: bad checksum, ID mismatch with bad checksum, ID mismatch alone
        vecs[6] = vecs[3];
        vecs[6].rq = 2'b01; vecs[6].rx = {32'd0, 8'hFD, 8'h00, 8'h02, 8'h01, 8'hFF, 8'hFF}; vecs[6].err = 2'd2; vecs[6].stat = 8'h00;
        vecs[7] = vecs[2];
        vecs[7].rq = 2'b10; vecs[7].rx = {32'd0, 8'hFC, 8'h00, 8'h02, 8'h02, 8'hFF, 8'hFF}; vecs[7].err = 2'd3;
        vecs[8] = vecs[6];
        vecs[8].rx = {32'd0, 8'hFB, 8'h00, 8'h02, 8'h02, 8'hFF, 8'hFF}; vecs[8].err = 2'd3;
        // leading garbage and a lone FF before the real header
        vecs[9] = vecs[6];
        vecs[9].nrx = 4'd9; vecs[9].rx = {8'hFC, 8'h00, 8'h02, 8'h01, 8'hFF, 8'hFF, 8'h12, 8'hFF, 8'h00}; vecs[9].err = 2'd0;
        // no reply, then broadcast write
        vecs[10] = vecs[0];
        vecs[10].nrx = 4'd0; vecs[10].err = 2'd1; vecs[10].chk_st = 1'b0; vecs[10].chk_rd = 1'b0;
        vecs[11] = mk(2'b01, 2'b01, 8'hFE, 8'h03, 8'h1E, 16'h0200, 4'd9,
                      {8'hD9, 8'h02, 8'h00, 8'h1E, 8'h03, 8'h05, 8'hFE, 8'hFF, 8'hFF}, 4'd0,
                      80'd0, 2'd0, 1'b0, 1'b0, 8'h00, 16'h0000);

        reset = 1'b1; req = 2'b00; tx_ready = 1'b0; tx_busy = 1'b0; rx_data = 8'h00; rx_valid = 1'b0;
        cmd_id = 16'h0; cmd_instr = 16'h0; cmd_addr = 16'h0; cmd_data = 32'h0;
        repeat (3) @(negedge clk);
        check("rst_ctrl", gnt == 2'b00 && !tx_valid && tx_data == 8'h00 && !dir && !done,
              {19'd0, gnt, tx_valid, tx_data, dir, done}, 32'd0);
        check("rst_result", err_code == 2'd0 && status == 8'h00 && rdata == 16'h0000,
              {6'd0, err_code, status, rdata}, 32'd0);
        reset = 1'b0;
        @(negedge clk);

        // reply bytes while idle must not produce a completion
        n = 0;
        for (int j = 0; j < 6; j++) begin
            rx_data = (j < 2) ? 8'hFF : 8'h01; rx_valid = 1'b1;
            @(negedge clk);
            if (done || gnt != 2'b00) n++;
        end
        rx_valid = 1'b0;
        check("idle_rx_ignored", n == 0, n, 0);

        for (int i = 0; i < 12; i++) run_vec(vecs[i]);
        req = 2'b00;
        @(negedge clk);

        // reset while the fourth byte is held on the bus
        cmd_id[7:0] = 8'h01; cmd_instr[7:0] = 8'h03; cmd_addr[7:0] = 8'h1E; cmd_data[15:0] = 16'h0200;
        req = 2'b01; tx_ready = 1'b1; tx_busy = 1'b1;
        @(negedge clk);
        repeat (3) @(negedge clk);
        tx_ready = 1'b0;
        check("pre_rst_byte3", tx_valid && tx_data == 8'h05, {23'd0, tx_valid, tx_data}, 32'h105);
        reset = 1'b1;
        #1;
        check("mid_tx_reset", !dir && !tx_valid && gnt == 2'b00 && tx_data == 8'h00,
              {20'd0, dir, tx_valid, gnt, tx_data}, 32'd0);
        req = 2'b00;
        @(negedge clk);
        reset = 1'b0;
        n = 0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (done) n++;
        end
        check("no_done_after_reset", n == 0, n, 0);
        vecs[1].drop = 1'b0;
        run_vec(vecs[1]);
        req = 2'b00;
        @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/dyna_bus_sequencer.md
DYNA_BUS_SEQUENCER -- requirements
Module: dyna_bus_sequencer

Interface
REQ-001 SHALL have parameter TIMEOUT_CYC, default 50000, which is the status-reply window in clock cycles (1 ms at 50 MHz).
REQ-002 SHALL have parameter TURN_CYC, default 100, which is the bus turnaround guard in cycles after TX drains.
REQ-003 SHALL have port CLOCK_50, input, 1 bit: system clock, all logic rising-edge.
REQ-004 SHALL have port reset, input, 1 bit: asynchronous, active-high.
REQ-005 SHALL have port req, input, 2 bits: per-requester command request, level, held until done.
REQ-006 SHALL have port cmd_id, input, 16 bits: servo ID, requester n at bits [8n+7:8n].
REQ-007 SHALL have port cmd_instr, input, 16 bits: instruction byte per requester, same packing as cmd_id.
REQ-008 SHALL have port cmd_addr, input, 16 bits: control-table address per requester, same packing as cmd_id.
REQ-009 SHALL have port cmd_data, input, 32 bits: write data per requester, at bits [16n+15:16n].
REQ-010 SHALL have port gnt, output, 2 bits: one-hot grant, held from latch to done.
REQ-011 SHALL have port tx_data, output, 8 bits: byte to UART serializer.
REQ-012 SHALL have port tx_valid, output, 1 bit, and port tx_ready, input, 1 bit: byte handshake; a transfer occurs when both are high.
REQ-013 SHALL have port tx_busy, input, 1 bit: serializer still shifting.
REQ-014 SHALL have port rx_data, input, 8 bits, and port rx_valid, input, 1 bit: received byte, single-cycle strobe.
REQ-015 SHALL have port dir, output, 1 bit: half-duplex driver enable, 1 = transmit.
REQ-016 SHALL have port done, output, 1 bit: one-cycle completion pulse.
REQ-017 SHALL have port err_code, output, 2 bits: 0 ok, 1 timeout, 2 checksum, 3 ID mismatch.
REQ-018 SHALL have port status, output, 8 bits: servo error byte from reply, and port rdata, output, 16 bits: first two reply params, little-endian.

Function
REQ-019 SHALL implement states IDLE, TX, DRAIN, RX, DONE.
REQ-020 In IDLE, on any req, SHALL grant round-robin: a lone requester wins; if both request, the one not last served wins. The selected command SHALL be latched, gnt set and dir=1 in the same cycle, then enter TX.
REQ-021 For instr 0x03 (WRITE), TX SHALL send FF FF ID 05 03 addr data_lo data_hi CHK.
REQ-022 For instr 0x02 (READ), TX SHALL send FF FF ID 04 02 addr 02 CHK.
REQ-023 For any other instr, TX SHALL send FF FF ID 02 instr CHK.
REQ-024 CHK SHALL be the bitwise NOT of the 8-bit wrap-around sum of ID, LEN, instr and params.
REQ-025 tx_data and tx_valid SHALL stay stable until tx_ready; the next byte SHALL be presented the cycle after a transfer, with no bubbles required.
REQ-026 After the CHK transfer, SHALL enter DRAIN and wait for tx_busy=0 plus TURN_CYC cycles, then drop dir to 0.
REQ-027 On leaving DRAIN, if ID=0xFE (broadcast), SHALL go to DONE with err_code=0; otherwise SHALL go to RX.
REQ-028 In RX, a single TIMEOUT_CYC counter SHALL start on entry and SHALL NOT be restarted by bytes; on expiry, SHALL set err_code=1 and go to DONE.
REQ-029 In RX, SHALL discard bytes until two consecutive 0xFF are received, then capture ID, LEN, ERR, LEN-2 params and CHK.
REQ-030 The first two params SHALL be written to rdata[7:0] and rdata[15:8]; further params SHALL be summed but not stored.
REQ-031 Reply ID differing from the command ID SHALL set err_code=3 after the full packet; checksum mismatch SHALL set err_code=2; ID mismatch SHALL take precedence.
REQ-032 DONE SHALL pulse done for exactly one cycle, clear gnt, record the last-served requester and return to IDLE.
REQ-033 A req deasserted mid-transaction SHALL be ignored; the transaction SHALL complete.
REQ-034 rx_valid outside RX SHALL be ignored.
REQ-035 err_code, status and rdata SHALL hold until the next DONE.

Reset
REQ-036 While reset is high, SHALL force IDLE, gnt=0, tx_valid=0, tx_data=0, dir=0, done=0, err_code=0, status=0, rdata=0, clear counters and set round-robin priority to requester 0.
REQ-037 Reset asserted mid-TX or mid-RX SHALL abort without a done pulse.

Verification
REQ-038 req=01, ID 01, WRITE, addr 1E, data 0x0200 -> TX bytes FF FF 01 05 03 1E 00 02 D6, dir=1; then reply FF FF 01 02 00 FC -> done, err_code=0, status=00.
REQ-039 req=10, READ ID 01 addr 24 -> TX FF FF 01 04 02 24 02 D2; then reply FF FF 01 04 00 00 02 F8 -> rdata=0x0200, err_code=0.
REQ-040 Both req held, requester 0 last served -> gnt=10 first, then 01; alternation continues for 4 transactions.
REQ-041 No reply after TX -> done exactly TIMEOUT_CYC cycles after RX entry, err_code=1; with ID FE, done with no RX wait.
REQ-042 Reply with CHK FD -> err_code=2; reply with ID 02 -> err_code=3; tx_ready held low 20 cycles -> tx_data stable throughout.
REQ-043 reset during the 4th TX byte -> dir=0, tx_valid=0, gnt=0 immediately, no done pulse, and the next request starts with FF.
